conv_frame_sequencer: RTL and testbench

// Frame-level controller for the convolution pipeline (sliding window -> roller -> linear -> rounding).

---
 rtl/conv_frame_sequencer_pkg.sv | 22 ++
 rtl/conv_frame_sequencer_if.sv | 37 +++
 rtl/conv_frame_sequencer_pos_counter.sv | 73 +++++++
 rtl/conv_frame_sequencer.sv | 149 ++++++++++++++
 tb/tb_conv_frame_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_frame_sequencer_pkg.sv
// Shared types and helpers for the convolution frame sequencer.
//   seq_state_e   : frame FSM states
//   conv_out_dim  : output dimension of a strided, padded window sweep
//   tag_width     : bit width for an index in 0..n-1 (never narrower than 1)
package conv_frame_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } seq_state_e;

    function automatic int conv_out_dim(input int in_dim, input int k, input int pad, input int stride);
        return (in_dim + 2 * pad - k) / stride + 1;
    endfunction

    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_frame_sequencer_if.sv
// Stream handshakes around the convolution instance plus the output-beat tags.
//   src_*      : upstream activation stream into the sequencer
//   conv_in_*  : gated activation stream into the convolution
//   conv_out_* : result stream out of the convolution
//   dst_*      : gated result stream to the downstream sink
//   out_y/out_x/out_ch_blk/out_last : position tags of the beat on dst
// master = sequencer side, slave = surrounding source/conv/sink side.
interface conv_frame_sequencer_if #(
    parameter int Y_W  = 2,
    parameter int X_W  = 3,
    parameter int CB_W = 1
);
    logic            src_valid;
    logic            src_ready;
    logic            conv_in_valid;
    logic            conv_in_ready;
    logic            conv_out_valid;
    logic            conv_out_ready;
    logic            dst_valid;
    logic            dst_ready;
    logic [Y_W-1:0]  out_y;
    logic [X_W-1:0]  out_x;
    logic [CB_W-1:0] out_ch_blk;
    logic            out_last;

    modport master (
        input  src_valid, conv_in_ready, conv_out_valid, dst_ready,
        output src_ready, conv_in_valid, conv_out_ready, dst_valid,
        output out_y, out_x, out_ch_blk, out_last
    );

    modport slave (
        output src_valid, conv_in_ready, conv_out_valid, dst_ready,
        input  src_ready, conv_in_valid, conv_out_ready, dst_valid,
        input  out_y, out_x, out_ch_blk, out_last
    );
endinterface

// File: rtl/conv_frame_sequencer_pos_counter.sv
// Three-level wrapping position counter for output beats.
//   clk, rst : clock, asynchronous active-low reset
//   en       : advance one position (ch_blk fastest, then x, then y)
//   clr      : synchronous return to (0,0,0); wins over en
//   ch_blk/x/y : current position
//   last     : current position is the final one of the frame
module conv_pos_counter #(
    parameter int N_CB = 2,
    parameter int N_X  = 6,
    parameter int N_Y  = 3,
    parameter int CB_W = 1,
    parameter int X_W  = 3,
    parameter int Y_W  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clr,
    output logic [CB_W-1:0] ch_blk,
    output logic [X_W-1:0]  x,
    output logic [Y_W-1:0]  y,
    output logic            last
);
    logic [CB_W-1:0] cb_q, cb_d;
    logic [X_W-1:0]  x_q, x_d;
    logic [Y_W-1:0]  y_q, y_d;
    logic            cb_end, x_end, y_end;

    always_comb begin
        cb_end = (cb_q == CB_W'(N_CB - 1));
        x_end  = (x_q == X_W'(N_X - 1));
        y_end  = (y_q == Y_W'(N_Y - 1));
        last   = cb_end && x_end && y_end;

        cb_d = cb_q;
        x_d  = x_q;
        y_d  = y_q;
        if (clr) begin
            cb_d = '0;
            x_d  = '0;
            y_d  = '0;
        end else if (en) begin
            // Carry ripples upward; the final position wraps to all zeros.
            if (cb_end) begin
                cb_d = '0;
                if (x_end) begin
                    x_d = '0;
                    y_d = y_end ? '0 : y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end else begin
                cb_d = cb_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cb_q <= '0;
            x_q  <= '0;
            y_q  <= '0;
        end else begin
            cb_q <= cb_d;
            x_q  <= x_d;
            y_q  <= y_d;
        end
    end

    assign ch_blk = cb_q;
    assign x      = x_q;
    assign y      = y_q;
endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame-level controller for the convolution pipeline. Gates the activation
// input and result output handshakes per frame, counts beats, tags each output
// beat with its (y, x, ch_blk) position and pulses done at frame end.
//   clk, rst : clock, asynchronous active-low reset
//   start    : begin a frame (only honoured in IDLE)
//   busy     : frame in progress (RUN or DRAIN)
//   done     : one-cycle pulse when the frame completes
//   err      : sticky; outputs finished before all inputs arrived; cleared by start
//   bus      : gated handshakes and output tags
module conv_frame_sequencer
    import conv_frame_sequencer_pkg::*;
#(
    parameter int IN_X         = 3,
    parameter int IN_Y         = 2,
    parameter int IN_C         = 4,
    parameter int UNROLL_IN_C  = 2,
    parameter int OUT_C        = 4,
    parameter int UNROLL_OUT_C = 2,
    parameter int KERNEL_X     = 2,
    parameter int KERNEL_Y     = 2,
    parameter int PADDING_X    = 2,
    parameter int PADDING_Y    = 1,
    parameter int STRIDE       = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic err,
    conv_frame_sequencer_if.master bus
);
    localparam int OUT_X    = conv_out_dim(IN_X, KERNEL_X, PADDING_X, STRIDE);
    localparam int OUT_Y    = conv_out_dim(IN_Y, KERNEL_Y, PADDING_Y, STRIDE);
    localparam int IN_BEATS = IN_X * IN_Y * IN_C / UNROLL_IN_C;
    localparam int OCB      = OUT_C / UNROLL_OUT_C;
    localparam int IN_CNT_W = $clog2(IN_BEATS + 1);
    localparam int Y_W      = tag_width(OUT_Y);
    localparam int X_W      = tag_width(OUT_X);
    localparam int CB_W     = tag_width(OCB);

    seq_state_e          state_q, state_d;
    logic [IN_CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic                err_q, err_d;

    logic            run, drain;
    logic            in_beat, out_beat, in_final, out_final;
    logic            pos_clr, pos_last;
    logic [CB_W-1:0] pos_cb;
    logic [X_W-1:0]  pos_x;
    logic [Y_W-1:0]  pos_y;

    conv_pos_counter #(
        .N_CB (OCB),
        .N_X  (OUT_X),
        .N_Y  (OUT_Y),
        .CB_W (CB_W),
        .X_W  (X_W),
        .Y_W  (Y_W)
    ) u_pos (
        .clk    (clk),
        .rst    (rst),
        .en     (out_beat),
        .clr    (pos_clr),
        .ch_blk (pos_cb),
        .x      (pos_x),
        .y      (pos_y),
        .last   (pos_last)
    );

    always_comb begin
        run   = (state_q == RUN);
        drain = (state_q == DRAIN);

        bus.conv_in_valid  = bus.src_valid && run;
        bus.src_ready      = bus.conv_in_ready && run;
        bus.dst_valid      = bus.conv_out_valid && (run || drain);
        bus.conv_out_ready = bus.dst_ready && (run || drain);

        in_beat   = bus.src_valid && bus.src_ready;
        out_beat  = bus.conv_out_valid && bus.conv_out_ready;
        in_final  = in_beat && (in_cnt_q == IN_CNT_W'(IN_BEATS - 1));
        out_final = out_beat && pos_last;

        state_d  = state_q;
        in_cnt_d = in_cnt_q;
        err_d    = err_q;
        pos_clr  = 1'b0;

        if (in_beat) begin
            in_cnt_d = in_final ? '0 : in_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                // A final output ends the frame even if inputs are short; a
                // coincident final input is a clean finish, otherwise flag it.
                if (out_final) begin
                    state_d = DONE;
                    if (!in_final) begin
                        err_d    = 1'b1;
                        in_cnt_d = '0;
                    end
                end else if (in_final) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_final) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d  = IDLE;
                in_cnt_d = '0;
                pos_clr  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            in_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_cnt_q <= in_cnt_d;
            err_q    <= err_d;
        end
    end

    assign busy           = (state_q == RUN) || (state_q == DRAIN);
    assign done           = (state_q == DONE);
    assign err            = err_q;
    assign bus.out_y      = pos_y;
    assign bus.out_x      = pos_x;
    assign bus.out_ch_blk = pos_cb;
    assign bus.out_last   = pos_last;
endmodule

// File: tb/tb_conv_frame_sequencer.sv
module tb_conv_frame_sequencer;
    localparam int OUT_X     = 6;
    localparam int OUT_Y     = 3;
    localparam int OCB       = 2;
    localparam int IN_BEATS  = 12;
    localparam int OUT_BEATS = OUT_X * OUT_Y * OCB;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy, done, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_frame_sequencer_if #(.Y_W(2), .X_W(3), .CB_W(1)) bus ();

    conv_frame_sequencer dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bus   (bus)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.src_valid      = 1'b0;
        bus.conv_in_ready  = 1'b0;
        bus.conv_out_valid = 1'b0;
        bus.dst_ready      = 1'b0;
    endtask

    function automatic bit coin();
        return ($urandom & 1) == 1;
    endfunction

    // Expected tag word {y, x, ch_blk, last} for output beat k of a frame.
    function automatic logic [6:0] exp_tag(input int k);
        int cb, x, y;
        cb = k % OCB;
        x  = (k / OCB) % OUT_X;
        y  = k / (OCB * OUT_X);
        return {2'(y), 3'(x), 1'(cb), (k == OUT_BEATS - 1)};
    endfunction

    // Runs one frame: pulses start, feeds n_in input beats, then offers outputs.
    // With overlap, all but the final output may be accepted while inputs flow.
    task automatic run_frame(input bit stall, input bit overlap, input int n_in,
                             output int in_got, output int out_got,
                             output int dones, output int done_lag);
        int ic, oc, cyc, last_cyc;
        logic [6:0] got;
        ic = 0; oc = 0; cyc = 0; last_cyc = -100;
        dones = 0; done_lag = -1;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL after_start busy=%b err=%b required busy=1 err=0", busy, err);
        end
        while (dones == 0 && cyc < 2000) begin
            bus.src_valid      = ((ic < n_in) || (n_in == IN_BEATS)) && (!stall || coin());
            bus.conv_in_ready  = !stall || coin();
            bus.conv_out_valid = (oc < OUT_BEATS) && ((ic >= n_in) || (overlap && oc < OUT_BEATS - 1))
                                 && (!stall || coin());
            bus.dst_ready      = !stall || coin();
            @(negedge clk);
            if (bus.dst_valid) begin
                got = {bus.out_y, bus.out_x, bus.out_ch_blk, bus.out_last};
                checks++;
                if (got !== exp_tag(oc)) begin
                    errors++;
                    $display("FAIL tag beat %0d got %b required %b", oc, got, exp_tag(oc));
                end
            end
            if (ic >= IN_BEATS && bus.src_valid) begin
                checks++;
                if (bus.src_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL drain_src_ready got %b required 0", bus.src_ready);
                end
            end
            if (bus.src_valid && bus.src_ready) ic++;
            if (bus.dst_valid && bus.dst_ready) begin
                oc++;
                if (oc == OUT_BEATS) last_cyc = cyc;
            end
            if (done) begin
                dones++;
                done_lag = cyc - last_cyc;
            end
            step();
            cyc++;
        end
        idle_inputs();
        in_got  = ic;
        out_got = oc;
        if (dones == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout in=%0d out=%0d required done", ic, oc);
        end
    endtask

    task automatic test_reset();
        logic [6:0] ctl;
        rst   = 1'b0;
        start = 1'b0;
        bus.src_valid      = 1'b1;
        bus.conv_in_ready  = 1'b1;
        bus.conv_out_valid = 1'b1;
        bus.dst_ready      = 1'b1;
        step();
        step();
        ctl = {bus.src_ready, bus.conv_in_valid, bus.dst_valid, bus.conv_out_ready, busy, done, err};
        checks++;
        if (ctl !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b required 0000000", ctl);
        end
        checks++;
        if ({bus.out_y, bus.out_x, bus.out_ch_blk} !== 6'b0) begin
            errors++;
            $display("FAIL reset_tags got %b required 000000", {bus.out_y, bus.out_x, bus.out_ch_blk});
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            ctl = {bus.src_ready, bus.conv_in_valid, bus.dst_valid, bus.conv_out_ready, busy, done, err};
            checks++;
            if (ctl !== 7'b0) begin
                errors++;
                $display("FAIL idle_ctl cycle %0d got %b required 0000000", i, ctl);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic check_frame_end(input string name, input int in_got, input int out_got,
                                   input int dones, input int done_lag, input int n_in, input bit exp_err);
        checks++;
        if (in_got != n_in || out_got != OUT_BEATS) begin
            errors++;
            $display("FAIL %s_counts in=%0d out=%0d required in=%0d out=%0d", name, in_got, out_got, n_in, OUT_BEATS);
        end
        checks++;
        if (dones != 1 || done_lag != 1) begin
            errors++;
            $display("FAIL %s_done dones=%0d lag=%0d required dones=1 lag=1", name, dones, done_lag);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== exp_err) begin
            errors++;
            $display("FAIL %s_after busy=%b done=%b err=%b required busy=0 done=0 err=%b", name, busy, done, err, exp_err);
        end
    endtask

    task automatic test_basic_frame();
        int ig, og, dn, lag;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_pre_busy got %b required 0", busy);
        end
        run_frame(1'b0, 1'b0, IN_BEATS, ig, og, dn, lag);
        check_frame_end("basic", ig, og, dn, lag, IN_BEATS, 1'b0);
    endtask

    task automatic test_random_stalls();
        int ig, og, dn, lag;
        for (int f = 0; f < 4; f++) begin
            run_frame(1'b1, 1'b1, IN_BEATS, ig, og, dn, lag);
            check_frame_end("stall", ig, og, dn, lag, IN_BEATS, 1'b0);
            step();
        end
    endtask

    task automatic test_early_output_err();
        int ig, og, dn, lag;
        run_frame(1'b0, 1'b0, 10, ig, og, dn, lag);
        check_frame_end("err", ig, og, dn, lag, 10, 1'b1);
        step();
        step();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b required 1", err);
        end
        run_frame(1'b1, 1'b1, IN_BEATS, ig, og, dn, lag);
        check_frame_end("post_err", ig, og, dn, lag, IN_BEATS, 1'b0);
    endtask

    task automatic test_reset_mid_drain();
        int ic, oc, cyc, ig, og, dn, lag;
        logic [6:0] ctl;
        ic = 0; oc = 0; cyc = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        while (oc < 20 && cyc < 500) begin
            bus.src_valid      = (ic < IN_BEATS);
            bus.conv_in_ready  = 1'b1;
            bus.conv_out_valid = (ic >= IN_BEATS);
            bus.dst_ready      = 1'b1;
            @(negedge clk);
            if (bus.src_valid && bus.src_ready) ic++;
            if (bus.dst_valid && bus.dst_ready) oc++;
            step();
            cyc++;
        end
        checks++;
        if (oc != 20 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_reach out=%0d busy=%b required out=20 busy=1", oc, busy);
        end
        bus.src_valid      = 1'b1;
        bus.conv_out_valid = 1'b1;
        rst = 1'b0;
        #2;
        ctl = {bus.src_ready, bus.conv_in_valid, bus.dst_valid, bus.conv_out_ready, busy, done, err};
        checks++;
        if (ctl !== 7'b0) begin
            errors++;
            $display("FAIL midreset_ctl got %b required 0000000", ctl);
        end
        checks++;
        if ({bus.out_y, bus.out_x, bus.out_ch_blk, bus.out_last} !== 7'b0) begin
            errors++;
            $display("FAIL midreset_tags got %b required 0000000",
                     {bus.out_y, bus.out_x, bus.out_ch_blk, bus.out_last});
        end
        idle_inputs();
        step();
        rst = 1'b1;
        step();
        run_frame(1'b0, 1'b0, IN_BEATS, ig, og, dn, lag);
        check_frame_end("post_reset", ig, og, dn, lag, IN_BEATS, 1'b0);
    endtask

    task automatic test_back_to_back();
        int fic, foc, total, dones, cyc;
        logic [6:0] got;
        fic = 0; foc = 0; total = 0; dones = 0; cyc = 0;
        start = 1'b1;
        bus.src_valid     = 1'b1;
        bus.conv_in_ready = 1'b1;
        bus.dst_ready     = 1'b1;
        while (dones < 2 && cyc < 400) begin
            bus.conv_out_valid = (fic >= IN_BEATS) && (foc < OUT_BEATS);
            @(negedge clk);
            if (bus.dst_valid) begin
                got = {bus.out_y, bus.out_x, bus.out_ch_blk, bus.out_last};
                checks++;
                if (got !== exp_tag(foc)) begin
                    errors++;
                    $display("FAIL b2b_tag frame %0d beat %0d got %b required %b", dones, foc, got, exp_tag(foc));
                end
            end
            if (bus.src_valid && bus.src_ready) fic++;
            if (bus.dst_valid && bus.dst_ready) begin
                foc++;
                total++;
            end
            if (done) begin
                checks++;
                if (fic != IN_BEATS || foc != OUT_BEATS) begin
                    errors++;
                    $display("FAIL b2b_frame %0d in=%0d out=%0d required in=%0d out=%0d",
                             dones, fic, foc, IN_BEATS, OUT_BEATS);
                end
                dones++;
                fic = 0;
                foc = 0;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        idle_inputs();
        checks++;
        if (dones != 2 || total != 2 * OUT_BEATS) begin
            errors++;
            $display("FAIL b2b_total dones=%0d out=%0d required dones=2 out=%0d", dones, total, 2 * OUT_BEATS);
        end
        step();
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle busy=%b required 0", busy);
        end
    endtask

    initial begin
        idle_inputs();
        start = 1'b0;
        rst   = 1'b0;
        test_reset();
        test_basic_frame();
        test_random_stalls();
        test_early_output_err();
        test_reset_mid_drain();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
